// File: rtl/fmul_pkg.sv
// FP32 field positions, result class flag layout and the flag bundle type
// shared by the multiplier result queue and its classifier.
package fmul_pkg;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int FRAC_W  = 23;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  localparam int FLAG_NAN  = 3;
  localparam int FLAG_INF  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_SUB  = 0;

  // Field order gives nan at bit 3 down to subnormal at bit 0.
  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic sub;
  } fp32_flags_t;
endpackage

// File: rtl/fmul_result_queue_if.sv
// Issue-side credit handshake, multiplier result input and FWFT result port.
// slave = the result queue, master = the issuing/consuming agent.
interface fmul_result_queue_if
  import fmul_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
);
  logic                   issue_valid;
  logic [TAG_W-1:0]       issue_tag;
  logic                   issue_ready;
  logic [31:0]            mul_z;
  logic                   res_valid;
  logic                   res_ready;
  logic [31:0]            res_data;
  logic [TAG_W-1:0]       res_tag;
  fp32_flags_t            res_flags;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   overflow_err;

  modport master (
    output issue_valid, issue_tag, mul_z, res_ready,
    input  issue_ready, res_valid, res_data, res_tag, res_flags, occupancy, overflow_err
  );

  modport slave (
    input  issue_valid, issue_tag, mul_z, res_ready,
    output issue_ready, res_valid, res_data, res_tag, res_flags, occupancy, overflow_err
  );
endinterface

// File: rtl/fmul_result_queue_classify.sv
// Combinational FP32 class decode of the multiplier output; with FMUL_FTZ_EN
// defined, subnormals are flushed to signed zero and flagged zero+subnormal.
module fp32_classify
  import fmul_pkg::*;
(
  input  logic [31:0] i_z,
  output logic [31:0] o_data,
  output fp32_flags_t o_flags
);
  logic [7:0] w_exp;
  logic       w_frac_nz;

  assign w_exp     = i_z[EXP_MSB:EXP_LSB];
  assign w_frac_nz = |i_z[FRAC_W-1:0];

  always_comb begin
    o_flags = '0;
    o_data  = i_z;
    if (w_exp == EXP_MAX) begin
      o_flags.nan = w_frac_nz;
      o_flags.inf = ~w_frac_nz;
    end else if (w_exp == 8'h00) begin
      if (w_frac_nz) begin
        o_flags.sub = 1'b1;
`ifdef FMUL_FTZ_EN
        o_flags.zero = 1'b1;
        o_data       = {i_z[31], 31'b0};
`endif
      end else begin
        o_flags.zero = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fmul_result_queue.sv
// Captures each multiplier product LATENCY edges after issue into a FWFT queue; credits
// (queued + in flight < DEPTH) gate issue so a free-running pipe never overflows. Option: FMUL_FTZ_EN.
module fmul_result_queue
  import fmul_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 clrn,
  fmul_result_queue_if.slave   io_bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 4;

  logic [LATENCY-1:0] r_vld_sr;
  logic [TAG_W-1:0]   r_tag_sr [LATENCY];

  logic [31:0]        r_data  [DEPTH];
  logic [TAG_W-1:0]   r_tag   [DEPTH];
  fp32_flags_t        r_flags [DEPTH];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_occ;
  logic               r_ovf;

  logic [SW-1:0]      w_inflight;
  logic               w_issue_ready;
  logic               w_acc;
  logic               w_cap;
  logic               w_pop;
  logic               w_full;
  logic               w_write;
  logic [31:0]        w_cls_data;
  fp32_flags_t        w_cls_flags;

  fp32_classify u_classify (
    .i_z     (io_bus.mul_z),
    .o_data  (w_cls_data),
    .o_flags (w_cls_flags)
  );

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + SW'(r_vld_sr[i]);
    end
  end

  // Every accepted op already owns a slot, so a capture always has somewhere to land.
  assign w_issue_ready = (SW'(r_occ) + w_inflight) < SW'(DEPTH);
  assign w_acc         = io_bus.issue_valid & w_issue_ready;
  assign w_cap         = r_vld_sr[LATENCY-1];
  assign w_pop         = (r_occ != '0) & io_bus.res_ready;
  assign w_full        = (r_occ == CW'(DEPTH));
  assign w_write       = w_cap & (~w_full | w_pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_vld_sr <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag_sr[i] <= '0;
      end
    end else begin
      r_vld_sr[0] <= w_acc;
      r_tag_sr[0] <= io_bus.issue_tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
        r_tag_sr[i] <= r_tag_sr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i]  <= '0;
        r_tag[i]   <= '0;
        r_flags[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      // On full, a same-edge pop vacates the head slot that the write pointer now aliases.
      if (w_write) begin
        r_data[r_wptr]  <= w_cls_data;
        r_tag[r_wptr]   <= r_tag_sr[LATENCY-1];
        r_flags[r_wptr] <= w_cls_flags;
        r_wptr          <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_cap & w_full & ~w_pop) begin
        r_ovf <= 1'b1;
      end
      case ({w_write, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: ;
      endcase
    end
  end

  assign io_bus.issue_ready  = w_issue_ready;
  assign io_bus.res_valid    = (r_occ != '0);
  assign io_bus.res_data     = r_data[r_rptr];
  assign io_bus.res_tag      = r_tag[r_rptr];
  assign io_bus.res_flags    = r_flags[r_rptr];
  assign io_bus.occupancy    = r_occ;
  assign io_bus.overflow_err = r_ovf;
endmodule

// File: tb/tb_fmul_result_queue.sv
// Bench for fmul_result_queue: plays the multiplier (drives mul_z on the capture edge)
// and checks the queue against a queue-of-results reference model.
module tb_fmul_result_queue;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]      d;
    logic [TAG_W-1:0] tag;
    logic [3:0]       f;
  } res_t;

  typedef struct packed {
    logic [31:0]      z;
    logic [TAG_W-1:0] tag;
    logic [7:0]       age;
  } pend_t;

  logic clk;
  logic clrn;
  int   n_cmp;
  int   n_fail;
  int   dut_acc_cnt;
  res_t  res_q[$];
  pend_t pend_q[$];

  fmul_result_queue_if #(.TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();

  fmul_result_queue #(.LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk    (clk),
    .clrn   (clrn),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic res_t ref_class(input logic [31:0] z, input logic [TAG_W-1:0] t);
    res_t r;
    int unsigned e;
    int unsigned m;
    e = (z >> 23) % 256;
    m = z % (1 << 23);
    r.d = z;
    r.tag = t;
    r.f = 4'b0000;
    if (e == 255) r.f = (m != 0) ? 4'b1000 : 4'b0100;
    else if (e == 0 && m == 0) r.f = 4'b0010;
    else if (e == 0) begin
`ifdef FMUL_FTZ_EN
      r.f = 4'b0011;
      r.d = z & 32'h8000_0000;
`else
      r.f = 4'b0001;
`endif
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_z();
    logic [31:0] z;
    z = $urandom();
    case ($urandom_range(0, 5))
      0: z[30:23] = 8'hFF;
      1: begin z[30:23] = 8'hFF; z[22:0] = '0; end
      2: z[30:0] = '0;
      3: z[30:23] = 8'h00;
      default: ;
    endcase
    return z;
  endfunction

  // One clock: present inputs at the negedge, advance the model across the posedge,
  // return at the next negedge with outputs settled.
  task automatic drive(input bit iv, input logic [TAG_W-1:0] tg, input bit rr, input logic [31:0] zval);
    bit   m_ready, cap, pop, acc;
    res_t r;
    m_ready = (res_q.size() + pend_q.size()) < DEPTH;
    cap     = (pend_q.size() != 0) && (pend_q[0].age == 8'(LAT - 1));
    pop     = (res_q.size() != 0) && rr;
    acc     = iv && m_ready;
    bus.issue_valid = iv;
    bus.issue_tag   = tg;
    bus.res_ready   = rr;
    bus.mul_z       = cap ? pend_q[0].z : $urandom();
    if (iv && bus.issue_ready === 1'b1) dut_acc_cnt++;
    @(posedge clk);
    if (pop) void'(res_q.pop_front());
    if (cap) begin
      r = ref_class(pend_q[0].z, pend_q[0].tag);
      void'(pend_q.pop_front());
      if (res_q.size() < DEPTH) res_q.push_back(r);
    end
    foreach (pend_q[i]) pend_q[i].age = pend_q[i].age + 8'd1;
    if (acc) pend_q.push_back('{zval, tg, 8'd0});
    @(negedge clk);
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_tag = '0; bus.res_ready = 1'b0; bus.mul_z = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.res_valid); end
    n_cmp++; if ({bus.res_data, bus.res_tag, bus.res_flags} !== '0) begin n_fail++; $display("FAIL reset_head got %h/%h/%b want 0", bus.res_data, bus.res_tag, bus.res_flags); end
    n_cmp++; if (bus.occupancy !== '0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus.overflow_err); end
    n_cmp++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.issue_ready); end
    clrn = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 4'd5, 1'b0, 32'h40C0_0000);
    for (int i = 0; i < LAT - 1; i++) begin
      drive(1'b0, '0, 1'b0, '0);
      n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early cyc %0d got %b want 0", i, bus.res_valid); end
    end
    drive(1'b0, '0, 1'b0, '0);
    n_cmp++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", bus.res_valid); end
    n_cmp++; if ({bus.res_data, bus.res_tag, bus.res_flags} !== {32'h40C0_0000, 4'd5, 4'b0000}) begin
      n_fail++; $display("FAIL single_head got %h/%h/%b want 40c00000/5/0000", bus.res_data, bus.res_tag, bus.res_flags); end
    n_cmp++; if (bus.occupancy !== CW'(1)) begin n_fail++; $display("FAIL single_occ got %0d want 1", bus.occupancy); end
    drive(1'b0, '0, 1'b1, '0);
    n_cmp++; if (bus.res_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_pop got valid %b ready %b want 0/1", bus.res_valid, bus.issue_ready); end
  endtask

  task automatic test_backpressure();
    dut_acc_cnt = 0;
    for (int i = 0; i < 10; i++) drive(1'b1, TAG_W'(i), 1'b0, rand_z());
    n_cmp++; if (dut_acc_cnt != DEPTH) begin n_fail++; $display("FAIL bp_accepts got %0d want %0d", dut_acc_cnt, DEPTH); end
    n_cmp++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b want 0", bus.issue_ready); end
    n_cmp++; if (bus.occupancy !== CW'(DEPTH)) begin n_fail++; $display("FAIL bp_occ got %0d want %0d", bus.occupancy, DEPTH); end
    drive(1'b0, '0, 1'b1, '0);
    n_cmp++; if (bus.issue_ready !== 1'b1 || bus.occupancy !== CW'(DEPTH - 1)) begin
      n_fail++; $display("FAIL bp_repop got ready %b occ %0d want 1/%0d", bus.issue_ready, bus.occupancy, DEPTH - 1); end
    for (int k = 1; k < DEPTH; k++) begin
      n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_tag !== TAG_W'(k) || bus.res_data !== res_q[0].d) begin
        n_fail++; $display("FAIL bp_order got v%b tag %0d data %h want tag %0d data %h", bus.res_valid, bus.res_tag, bus.res_data, k, res_q[0].d); end
      drive(1'b0, '0, 1'b1, '0);
    end
  endtask

  task automatic test_streaming();
    int nxt, got;
    bit iv, rdy_m;
    nxt = 0; got = 0;
    for (int c = 0; c < 120 && got < 16; c++) begin
      iv    = (nxt < 16);
      rdy_m = (res_q.size() + pend_q.size()) < DEPTH;
      if (bus.res_valid === 1'b1) begin
        n_cmp++; if (bus.res_tag !== TAG_W'(got) || res_q.size() == 0 || bus.res_data !== res_q[0].d) begin
          n_fail++; $display("FAIL stream_order got tag %0d data %h want tag %0d", bus.res_tag, bus.res_data, got); end
        got++;
      end
      n_cmp++; if (bus.occupancy > CW'(1) || bus.overflow_err !== 1'b0) begin
        n_fail++; $display("FAIL stream_occ got occ %0d ovf %b want <=1/0", bus.occupancy, bus.overflow_err); end
      drive(iv, TAG_W'(nxt), 1'b1, rand_z());
      if (iv && rdy_m) nxt++;
    end
    n_cmp++; if (got != 16) begin n_fail++; $display("FAIL stream_count got %0d want 16", got); end
  endtask

  task automatic test_classes();
    logic [31:0] zin [4];
    logic [31:0] ed  [4];
    logic [3:0]  ef  [4];
    zin[0] = 32'h7FC0_0000; ed[0] = 32'h7FC0_0000; ef[0] = 4'b1000;
    zin[1] = 32'hFF80_0000; ed[1] = 32'hFF80_0000; ef[1] = 4'b0100;
    zin[2] = 32'h8000_0000; ed[2] = 32'h8000_0000; ef[2] = 4'b0010;
    zin[3] = 32'h0000_0001;
`ifdef FMUL_FTZ_EN
    ed[3] = 32'h0000_0000; ef[3] = 4'b0011;
`else
    ed[3] = 32'h0000_0001; ef[3] = 4'b0001;
`endif
    for (int k = 0; k < 4; k++) drive(1'b1, TAG_W'(k + 8), 1'b0, zin[k]);
    repeat (LAT) drive(1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ({bus.res_valid, bus.res_data, bus.res_flags} !== {1'b1, ed[k], ef[k]}) begin
        n_fail++; $display("FAIL class_%0d got v%b %h/%b want %h/%b", k, bus.res_valid, bus.res_data, bus.res_flags, ed[k], ef[k]); end
      drive(1'b0, '0, 1'b1, '0);
    end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 4; k++) drive(1'b1, TAG_W'(k), 1'b0, rand_z());
    drive(1'b0, '0, 1'b0, '0);
    n_cmp++; if (bus.occupancy !== CW'(2)) begin n_fail++; $display("FAIL rst_mid_pre got occ %0d want 2", bus.occupancy); end
    clrn = 1'b0;
    #1;
    n_cmp++; if ({bus.res_valid, bus.res_data, bus.res_tag, bus.res_flags} !== '0) begin
      n_fail++; $display("FAIL rst_mid_head got v%b %h/%h/%b want 0", bus.res_valid, bus.res_data, bus.res_tag, bus.res_flags); end
    n_cmp++; if (bus.occupancy !== '0 || bus.issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_state got occ %0d ready %b want 0/1", bus.occupancy, bus.issue_ready); end
    res_q.delete();
    pend_q.delete();
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1, '0);
      n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale cyc %0d got %b want 0", i, bus.res_valid); end
    end
  endtask

  task automatic test_full_simul();
    for (int k = 0; k < 4; k++) drive(1'b1, TAG_W'(k), 1'b0, rand_z());
    repeat (2) drive(1'b0, '0, 1'b0, '0);
    n_cmp++; if (bus.occupancy !== CW'(3) || bus.issue_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_pre got occ %0d ready %b want 3/0", bus.occupancy, bus.issue_ready); end
    drive(1'b0, '0, 1'b1, '0);
    n_cmp++; if (bus.occupancy !== CW'(3) || bus.overflow_err !== 1'b0) begin
      n_fail++; $display("FAIL full_simul got occ %0d ovf %b want 3/0", bus.occupancy, bus.overflow_err); end
    for (int k = 1; k < 4; k++) begin
      n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_tag !== TAG_W'(k) || bus.res_data !== res_q[0].d) begin
        n_fail++; $display("FAIL full_order got v%b tag %0d data %h want tag %0d data %h", bus.res_valid, bus.res_tag, bus.res_data, k, res_q[0].d); end
      drive(1'b0, '0, 1'b1, '0);
    end
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain got %b want 0", bus.res_valid); end
  endtask

  task automatic test_random();
    bit exp_v, exp_rdy;
    for (int c = 0; c < 400; c++) begin
      exp_v   = (res_q.size() != 0);
      exp_rdy = (res_q.size() + pend_q.size()) < DEPTH;
      n_cmp++; if (bus.res_valid !== exp_v || bus.occupancy !== CW'(res_q.size())) begin
        n_fail++; $display("FAIL rand_occ cyc %0d got v%b occ %0d want v%b occ %0d", c, bus.res_valid, bus.occupancy, exp_v, res_q.size()); end
      n_cmp++; if (bus.issue_ready !== exp_rdy || bus.overflow_err !== 1'b0) begin
        n_fail++; $display("FAIL rand_ready cyc %0d got rdy %b ovf %b want %b/0", c, bus.issue_ready, bus.overflow_err, exp_rdy); end
      if (exp_v) begin
        n_cmp++; if ({bus.res_data, bus.res_tag, bus.res_flags} !== res_q[0]) begin
          n_fail++; $display("FAIL rand_head cyc %0d got %h/%h/%b want %h/%h/%b", c, bus.res_data, bus.res_tag, bus.res_flags, res_q[0].d, res_q[0].tag, res_q[0].f); end
      end
      drive(1'($urandom_range(0, 3) != 0), TAG_W'($urandom()), 1'($urandom_range(0, 2) != 0), rand_z());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    dut_acc_cnt = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_classes();
    test_reset_midflight();
    test_full_simul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
